// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream_out_fifo slice.
package stream_pkg;

  localparam int unsigned STREAM_DATA_W = 8;
  localparam int unsigned STREAM_ID_W   = 1;

  // One buffered beat as it sits in storage.
  typedef struct packed {
    logic [STREAM_DATA_W-1:0] data;
    logic [STREAM_ID_W-1:0]   id;
    logic                     last;
  } stream_beat_t;

  // $clog2 that never yields zero, so a single-entry count still gets a bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Beat storage for stream_out_fifo: synchronous write, asynchronous
// (show-ahead) read. Contents are intentionally not reset.
module stream_fifo_mem
  import stream_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = clog2_min1(DEPTH),
  parameter int unsigned WIDTH      = $bits(stream_beat_t)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the accepted beat into its slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_out_fifo.sv
// Elastic output buffer behind a crossbar master port.
// Define STREAM_OUT_FIFO_PKT_MODE_EN for store-and-forward packet mode;
// without it the FIFO is cut-through.
module stream_out_fifo
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_ID_WIDTH   = 1,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [T_DATA_WIDTH-1:0]       s_data_i,
  input  logic [T_ID_WIDTH-1:0]         s_id_i,
  input  logic                          s_last_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic [T_DATA_WIDTH-1:0]       m_data_o,
  output logic [T_ID_WIDTH-1:0]         m_id_o,
  output logic                          m_last_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [clog2_min1(DEPTH):0]    count_o
);

  localparam int unsigned ADDR_WIDTH = clog2_min1(DEPTH);
  localparam int unsigned BEAT_W     = T_DATA_WIDTH + T_ID_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic [BEAT_W-1:0]     wr_beat;
  logic [BEAT_W-1:0]     rd_beat;
  logic                  push;
  logic                  pop;

  assign s_ready_o = (count_q != CNT_FULL);
  assign push      = s_valid_i & s_ready_o;
  assign pop       = m_valid_o & m_ready_i;
  assign count_o   = count_q;

  assign wr_beat = {s_data_i, s_id_i, s_last_i};
  assign {m_data_o, m_id_o, m_last_o} = rd_beat;

  stream_fifo_mem #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (BEAT_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_beat),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_beat)
  );

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef STREAM_OUT_FIFO_PKT_MODE_EN
  logic [ADDR_WIDTH:0] pkt_cnt_q, pkt_cnt_d;
  logic                push_last;
  logic                pop_last;

  assign push_last = push & s_last_i;
  assign pop_last  = pop & m_last_o;

  // A full FIFO is released even without a complete packet so that packets
  // longer than DEPTH stream out instead of deadlocking.
  assign m_valid_o = (pkt_cnt_q != '0) | (count_q == CNT_FULL);

  // Next-state for the count of complete packets held.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    unique case ({push_last, pop_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Complete-packet counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
`else
  assign m_valid_o = (count_q != '0);
`endif

endmodule

// File: tb/tb_stream_out_fifo.sv
// Scoreboard bench for stream_out_fifo (DEPTH = 8, 8-bit data, 1-bit id).
module tb_stream_out_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic [0:0] s_id = '0;
  logic       s_last = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic [0:0] m_id;
  logic       m_last;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;

  logic [9:0] exp_q[$];
  logic       stall_q = 1'b0;
  logic [9:0] stall_beat = '0;

  stream_out_fifo #(
    .T_DATA_WIDTH (8),
    .T_ID_WIDTH   (1),
    .DEPTH        (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_id_i    (s_id),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_id_o    (m_id),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .count_o   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] d, input logic id, input logic last);
    s_data  = d;
    s_id    = id;
    s_last  = last;
    s_valid = 1'b1;
    exp_q.push_back({d, id, last});
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks that
  // a stalled output stays valid and stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_beat", 32'({m_data, m_id, m_last}), 32'(stall_beat));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got 0x%0h required no beat at %0t",
                   {m_data, m_id, m_last}, $time);
        end else begin
          chk("out_beat", 32'({m_data, m_id, m_last}), 32'(exp_q.pop_front()));
        end
      end
      stall_q    = m_valid && !m_ready;
      stall_beat = {m_data, m_id, m_last};
    end
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    step();

`ifdef STREAM_OUT_FIFO_PKT_MODE_EN
    // 4-beat packet is held until its last beat is stored
    for (int k = 0; k < 4; k++) begin
      issue(8'hA0 + 8'(k), k[0], k == 3);
      @(negedge clk);
      chk("pkt4_hold", 32'(m_valid), 32'd0);
      step();
    end
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("pkt4_burst", 32'(m_valid), 32'd1);
      step();
    end
    @(negedge clk);
    chk("pkt4_done", 32'(m_valid), 32'd0);
    step();
`else
    // Three beats through an empty FIFO with a ready sink
    issue(8'h11, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_no_bypass", 32'(m_valid), 32'd0);
    chk("t1_count0", 32'(count), 32'd0);
    step();
    issue(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_lat1", 32'(m_valid), 32'd1);
    chk("t1_count_b2", 32'(count), 32'd1);
    step();
    issue(8'h33, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_count_b3", 32'(count), 32'd1);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("t1_count_tail", 32'(count), 32'd1);
    step();
    @(negedge clk);
    chk("t1_empty", 32'(count), 32'd0);
    chk("t1_empty_valid", 32'(m_valid), 32'd0);
    step();
`endif

    // Fill to DEPTH with the sink stalled; the ninth beat waits at the source
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue(8'(i), i[0], 1'b1);
      @(negedge clk);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_ready", 32'(s_ready), 32'd1);
      step();
    end
    issue(8'h08, 1'b0, 1'b1);
    @(negedge clk);
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_valid", 32'(m_valid), 32'd1);
    step();
    @(negedge clk);
    chk("held_count", 32'(count), 32'd8);
    step();

    // Single pop while full: no push in the same cycle
    m_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_ready", 32'(s_ready), 32'd0);
    step();
    m_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_count", 32'(count), 32'd7);
    chk("after_pop_ready", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("refill_count", 32'(count), 32'd8);
    chk("refill_ready", 32'(s_ready), 32'd0);
    step();
    m_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(m_valid), 32'd0);
    step();

    // Push and pop every cycle; pointers wrap more than twice
    for (int i = 0; i < 20; i++) begin
      issue(8'h40 + 8'(i), i[0], 1'b1);
      @(negedge clk);
      chk("stream_count", 32'(count), (i == 0) ? 32'd0 : 32'd1);
      step();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("stream_tail", 32'(count), 32'd1);
    step();
    @(negedge clk);
    chk("stream_empty", 32'(count), 32'd0);
    step();

`ifdef STREAM_OUT_FIFO_PKT_MODE_EN
    // 10-beat packet at DEPTH 8: released when full, no deadlock
    for (int k = 0; k < 10; k++) begin
      int n;
      issue(8'hB0 + 8'(k), k[0], k == 9);
      @(negedge clk);
      if (k < 8) chk("big_hold", 32'(m_valid), 32'd0);
      if (k == 8) begin
        chk("big_full_count", 32'(count), 32'd8);
        chk("big_full_valid", 32'(m_valid), 32'd1);
      end
      n = 0;
      while (!s_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("big_accept_bound", 32'(s_ready), 32'd1);
      step();
    end
    s_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
        step();
        n++;
      end
    end
    chk("big_drained", 32'(exp_q.size()), 32'd0);
    step();
`endif

    // Reset mid-packet with 5 beats stored
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(8'h60 + 8'(i), 1'b0, 1'b0);
      step();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'd5);
    step();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_ready", 32'(s_ready), 32'd1);
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    step();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
